sdram_aref: RTL and testbench
=============================

SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports: sysclk_100M  in  1  100 MHz system clock; rst  in  1  async active-high reset.
REQ-002 init_end_flag  in  1  high once SDRAM power-up initialisation is complete.
REQ-003 aref_en  in  1  arbiter grant; starts a refresh burst when sampled high with aref_req high.
REQ-004 aref_req  out  1  refresh request to arbiter.
REQ-005 aref_end_flag  out  1  one-cycle pulse when the refresh burst is complete.
REQ-006 aref_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}: NOP=4'b0111, PRECHARGE=4'b0010, AUTO_REFRESH=4'b0001.
REQ-007 aref_ba  out  2  bank address, always 2'b11.
REQ-008 aref_addr  out  13  13'h0400 during PRECHARGE (A10=1, all banks), otherwise 13'h1FFF.
REQ-009 aref_overdue  out  1  sticky missed-deadline flag (see Configuration).
REQ-010 Parameters: AREF_PERIOD=780 (7.8 us at 100 MHz); T_RP=2 (NOP cycles after PRECHARGE); T_RC=7 (NOP cycles after each AUTO_REFRESH); AREF_NUM=2 (AUTO_REFRESH commands per burst).

Function
REQ-011 An internal init_done bit SHALL set on the first cycle init_end_flag is high and stay set until reset; later deassertion of init_end_flag SHALL be ignored.
REQ-012 While init_done is 0, the period counter SHALL be held at 0 and aref_req SHALL be 0.
REQ-013 Once init_done is 1, the period counter SHALL count 0..AREF_PERIOD-1 and wrap, free-running, including during a burst.
REQ-014 aref_req SHALL rise the cycle after the counter equals AREF_PERIOD-1 and hold until accepted.
REQ-015 Acceptance: state IDLE, aref_req=1 and aref_en=1 in the same cycle; aref_req SHALL clear the next cycle. aref_en with aref_req=0 SHALL be ignored.
REQ-016 FSM states: IDLE, PRE, TRP, AREF, TRC, DONE.
REQ-017 Transitions: IDLE->PRE on acceptance; PRE->TRP after 1 cycle; TRP->AREF after T_RP cycles; AREF->TRC after 1 cycle; TRC->AREF after T_RC cycles if fewer than AREF_NUM AUTO_REFRESH commands have been issued, else TRC->DONE; DONE->IDLE after 1 cycle.
REQ-018 Outputs are registered and follow the state: PRE gives PRECHARGE; AREF gives AUTO_REFRESH; all other states give NOP.
REQ-019 Default timing, with acceptance at cycle 0: PRECHARGE at cycle 1; AUTO_REFRESH at cycles 4 and 12; aref_end_flag=1 at cycle 20 only; IDLE at cycle 21.
REQ-020 If the counter wraps during a burst, aref_req SHALL still assert per REQ-014 and be serviced after DONE.
REQ-021 Wait and refresh counters SHALL be sized for their parameter and SHALL clear on every state entry.

Reset
REQ-022 When rst is asserted, the block SHALL, asynchronously: set the FSM to IDLE; clear all counters and init_done; drive aref_req=0, aref_end_flag=0, aref_cmd=4'b0111, aref_ba=2'b11, aref_addr=13'h1FFF, aref_overdue=0.
REQ-023 If reset occurs during a burst, the burst SHALL be abandoned without completion; after release, nothing SHALL be issued until init_end_flag is seen high again.

Configuration
REQ-024 Macro SDRAM_AREF_OVERDUE_EN, when defined: aref_overdue SHALL set (sticky until reset) when the counter reaches AREF_PERIOD-1 while aref_req is already 1.
REQ-025 Without SDRAM_AREF_OVERDUE_EN: the port SHALL remain present and tied to 0, and no overdue logic SHALL be synthesised.

Verification
REQ-026 Scenario 1: rst high 100 ns, then low, init_end_flag held 0 for 20 us -> aref_req stays 0 and aref_cmd stays 4'b0111 throughout.
REQ-027 Scenario 2: init_end_flag rises at cycle N, aref_en tied 0 -> aref_req rises at cycle N+781 and stays high.
REQ-028 Scenario 3: aref_en pulsed while aref_req=1 -> PRECHARGE with addr 13'h0400 at +1; AUTO_REFRESH at +4 and +12; aref_end_flag pulse at +20; aref_req low from +1.
REQ-029 Scenario 4: aref_en held low for 2 periods after aref_req rises -> aref_overdue=1 with macro defined, 0 without.
REQ-030 Scenario 5: rst asserted at cycle +6 of a burst -> outputs take reset values immediately; no command issued until init_end_flag is high again.
REQ-031 Scenario 6: init_end_flag dropped after init, and aref_en pulsed with aref_req=0 -> periodic requests continue unaffected; the aref_en pulse starts no burst.

Source files
------------

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: periodic request to an arbiter, then PRECHARGE-all plus AREF_NUM AUTO_REFRESH.
// Optional sticky missed-deadline flag under `ifdef SDRAM_AREF_OVERDUE_EN; default build ties aref_overdue to 0.
module sdram_aref #(
  parameter int AREF_PERIOD = 780,
  parameter int T_RP        = 2,
  parameter int T_RC        = 7,
  parameter int AREF_NUM    = 2
) (
  input  logic        sysclk_100M,
  input  logic        rst,
  input  logic        init_end_flag,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_end_flag,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_ba,
  output logic [12:0] aref_addr,
  output logic        aref_overdue
);

  localparam int CNT_W  = $clog2(AREF_PERIOD);
  localparam int WAIT_MAX = (T_RP > T_RC) ? T_RP : T_RC;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam int REF_W  = $clog2(AREF_NUM + 1);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PRE  = 4'b0010;
  localparam logic [3:0]  CMD_AREF = 4'b0001;
  localparam logic [12:0] ADDR_IDLE = 13'h1FFF;
  localparam logic [12:0] ADDR_PALL = 13'h0400;

  typedef enum logic [2:0] {IDLE, PRE, TRP, AREF, TRC, DONE} state_t;

  state_t            state;
  logic              init_done;
  logic [CNT_W-1:0]  period_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic              period_wrap;
  logic              accept;

  assign period_wrap = init_done && (period_cnt == CNT_W'(AREF_PERIOD - 1));
  assign accept      = (state == IDLE) && aref_req && aref_en;
  assign aref_ba     = 2'b11;

  // Period timer runs regardless of the FSM, so a wrap mid-burst queues the next request.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      init_done  <= 1'b0;
      period_cnt <= '0;
      aref_req   <= 1'b0;
    end else begin
      if (init_end_flag)
        init_done <= 1'b1;
      if (!init_done || period_wrap)
        period_cnt <= '0;
      else
        period_cnt <= period_cnt + 1'b1;
      if (period_wrap)
        aref_req <= 1'b1;
      else if (accept)
        aref_req <= 1'b0;
    end
  end

  // Outputs are loaded on the edge that enters a state, so they line up with that state.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      ref_cnt       <= '0;
      aref_cmd      <= CMD_NOP;
      aref_addr     <= ADDR_IDLE;
      aref_end_flag <= 1'b0;
    end else begin
      wait_cnt      <= '0;
      aref_cmd      <= CMD_NOP;
      aref_addr     <= ADDR_IDLE;
      aref_end_flag <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state     <= PRE;
          ref_cnt   <= '0;
          aref_cmd  <= CMD_PRE;
          aref_addr <= ADDR_PALL;
        end
        PRE: state <= TRP;
        TRP: begin
          if (wait_cnt == WAIT_W'(T_RP - 1)) begin
            state    <= AREF;
            ref_cnt  <= ref_cnt + 1'b1;
            aref_cmd <= CMD_AREF;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        AREF: state <= TRC;
        TRC: begin
          if (wait_cnt != WAIT_W'(T_RC - 1)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else if (ref_cnt < REF_W'(AREF_NUM)) begin
            state    <= AREF;
            ref_cnt  <= ref_cnt + 1'b1;
            aref_cmd <= CMD_AREF;
          end else begin
            state         <= DONE;
            aref_end_flag <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_AREF_OVERDUE_EN
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst)
      aref_overdue <= 1'b0;
    else if (period_wrap && aref_req)
      aref_overdue <= 1'b1;
  end
`else
  assign aref_overdue = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: directed scenarios plus a random phase, checked every cycle against a timeline model.
module tb_sdram_aref;

  localparam int AREF_PERIOD = 780;
  localparam int T_RP        = 2;
  localparam int T_RC        = 7;
  localparam int AREF_NUM    = 2;
  // Burst timeline, in cycles after the acceptance cycle.
  localparam int PRE_AT  = 1;
  localparam int AREF0   = PRE_AT + 1 + T_RP;
  localparam int END_AT  = AREF0 + AREF_NUM * (T_RC + 1);
`ifdef SDRAM_AREF_OVERDUE_EN
  localparam bit OVD_EN = 1'b1;
`else
  localparam bit OVD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        init_end_flag;
  logic        aref_en;
  logic        aref_req;
  logic        aref_end_flag;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        aref_overdue;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_init;
  int m_cnt;
  bit m_req;
  bit m_ovd;
  int m_pos;  // cycles since acceptance, -1 when no burst

  sdram_aref #(
    .AREF_PERIOD(AREF_PERIOD), .T_RP(T_RP), .T_RC(T_RC), .AREF_NUM(AREF_NUM)
  ) dut (
    .sysclk_100M  (clk),
    .rst          (rst),
    .init_end_flag(init_end_flag),
    .aref_en      (aref_en),
    .aref_req     (aref_req),
    .aref_end_flag(aref_end_flag),
    .aref_cmd     (aref_cmd),
    .aref_ba      (aref_ba),
    .aref_addr    (aref_addr),
    .aref_overdue (aref_overdue)
  );

  always #5 clk = ~clk;

  function automatic bit is_aref_cycle(int p);
    for (int k = 0; k < AREF_NUM; k++)
      if (p == AREF0 + k * (T_RC + 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_init = 0; m_cnt = 0; m_req = 0; m_ovd = 0; m_pos = -1;
  endtask

  task automatic model_edge();
    bit wrap, acc;
    if (rst) begin
      model_reset();
      return;
    end
    wrap = m_init && (m_cnt == AREF_PERIOD - 1);
    acc  = (m_pos < 0) && m_req && aref_en;
    if (OVD_EN && wrap && m_req) m_ovd = 1;
    if (wrap) m_req = 1;
    else if (acc) m_req = 0;
    m_cnt = !m_init ? 0 : (m_cnt + 1) % AREF_PERIOD;
    if (init_end_flag) m_init = 1;
    if (acc) m_pos = 1;
    else if (m_pos >= 1) m_pos = (m_pos >= END_AT) ? -1 : m_pos + 1;
  endtask

  task automatic check_all();
    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    e_cmd  = (m_pos == PRE_AT) ? 4'b0010 : is_aref_cycle(m_pos) ? 4'b0001 : 4'b0111;
    e_addr = (m_pos == PRE_AT) ? 13'h0400 : 13'h1FFF;
    checks++;
    assert (aref_req === m_req) else begin
      errors++; $error("FAIL req: got %b expected %b at %0t", aref_req, m_req, $time);
    end
    checks++;
    assert (aref_cmd === e_cmd) else begin
      errors++; $error("FAIL cmd: got %b expected %b at %0t", aref_cmd, e_cmd, $time);
    end
    checks++;
    assert (aref_addr === e_addr) else begin
      errors++; $error("FAIL addr: got %h expected %h at %0t", aref_addr, e_addr, $time);
    end
    checks++;
    assert (aref_end_flag === (m_pos == END_AT)) else begin
      errors++; $error("FAIL end_flag: got %b expected %b at %0t", aref_end_flag, (m_pos == END_AT), $time);
    end
    checks++;
    assert (aref_ba === 2'b11) else begin
      errors++; $error("FAIL ba: got %b expected 11 at %0t", aref_ba, $time);
    end
    checks++;
    assert (aref_overdue === m_ovd) else begin
      errors++; $error("FAIL overdue: got %b expected %b at %0t", aref_overdue, m_ovd, $time);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are checked 1 unit after it.
  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      #1;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; init_end_flag = 1'b0; aref_en = 1'b0;
    model_reset();
    #1;
    check_all();  // reset values
    #99;
    rst = 1'b0;
    #1;

    // Scenario 1: no init for 20 us
    step(2000);

    // Scenario 2: init rises, request latency
    init_end_flag = 1'b1;
    lat = 0;
    while (!aref_req && lat < 2000) begin
      step();
      lat++;
    end
    checks++;
    assert (lat == AREF_PERIOD + 1) else begin
      errors++; $error("FAIL req_latency: got %0d expected %0d", lat, AREF_PERIOD + 1);
    end

    // Scenario 4: request left pending for two periods
    step(2 * AREF_PERIOD);
    checks++;
    assert (aref_overdue === OVD_EN) else begin
      errors++; $error("FAIL overdue_sticky: got %b expected %b", aref_overdue, OVD_EN);
    end

    // Scenario 3: single-cycle grant
    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    checks++;
    assert (aref_cmd === 4'b0010 && aref_addr === 13'h0400 && aref_req === 1'b0) else begin
      errors++; $error("FAIL precharge_at_1: got cmd %b addr %h req %b expected 0010 0400 0", aref_cmd, aref_addr, aref_req);
    end
    step(END_AT - 1);
    checks++;
    assert (aref_end_flag === 1'b1) else begin
      errors++; $error("FAIL end_at_20: got %b expected 1", aref_end_flag);
    end
    step(5);

    // Scenario 6: init dropped, grant without request, then random traffic
    init_end_flag = 1'b0;
    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    step(AREF_PERIOD);
    for (int i = 0; i < 3000; i++) begin
      aref_en       = ($urandom_range(0, 9) == 0);
      init_end_flag = $urandom_range(0, 1);
      step();
    end
    aref_en = 1'b0;

    // Scenario 5: reset six cycles into a burst
    lat = 0;
    while (!aref_req && lat < 2000) begin
      step();
      lat++;
    end
    checks++;
    assert (aref_req === 1'b1) else begin
      errors++; $error("FAIL req_before_reset: got %b expected 1", aref_req);
    end
    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    step(5);
    init_end_flag = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();  // asynchronous reset takes effect mid-cycle
    step(3);
    rst = 1'b0;
    step(1000);
    init_end_flag = 1'b1;
    step();
    init_end_flag = 1'b0;
    step(AREF_PERIOD + 2);
    checks++;
    assert (aref_req === 1'b1) else begin
      errors++; $error("FAIL req_after_reinit: got %b expected 1", aref_req);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
